// File: rtl/seq_pkg.sv
// Shared types and constants for the stage sequencer: state encoding,
// index-width helper and the per-edge priority ordering.
package seq_pkg;

  // Run mode of the sequencer; the active stage index is held separately.
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } mode_t;

  // Stage index held while idle, and the fetch stage index.
  localparam int IDLE_IDX  = 0;
  localparam int FETCH_IDX = 0;

  // Per-edge priority of control inputs, highest first (lower code wins).
  localparam int PRI_RESET   = 0;
  localparam int PRI_HALT    = 1;
  localparam int PRI_START   = 2;
  localparam int PRI_STALL   = 3;
  localparam int PRI_ADVANCE = 4;

  // Width of a binary stage index for n stages.
  function automatic int sw_of(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/stage_sequencer_if.sv
// Control/status bundle between the core controller and the stage sequencer.
interface stage_sequencer_if #(
  parameter int N_STAGES = 5,
  parameter int CNT_W    = 16
);
  localparam int SW = seq_pkg::sw_of(N_STAGES);

  logic                start;
  logic                stall;
  logic                halt;
  logic [N_STAGES-1:0] skip_mask;
  logic [N_STAGES-1:0] stage_oh;
  logic [SW-1:0]       stage_idx;
  logic                busy;
  logic                retire;
  logic [CNT_W-1:0]    retire_count;

  // Controller side: issues commands, observes stage status.
  modport master (
    output start, stall, halt, skip_mask,
    input  stage_oh, stage_idx, busy, retire, retire_count
  );

  // Sequencer side.
  modport slave (
    input  start, stall, halt, skip_mask,
    output stage_oh, stage_idx, busy, retire, retire_count
  );
endinterface

// File: rtl/seq_next_stage.sv
// Finds the lowest non-skipped stage index strictly above the current one.
// The caller guarantees mask[N_STAGES-1] is clear, so a target always exists.
module seq_next_stage #(
  parameter int N_STAGES = 5,
  parameter int SW       = 3
) (
  input  logic [N_STAGES-1:0] mask,
  input  logic [SW-1:0]       cur,
  output logic [SW-1:0]       nxt
);

  // Scan from the top down so the lowest qualifying index is the last written.
  always_comb begin
    nxt = SW'(N_STAGES - 1);
    for (int j = N_STAGES - 1; j >= 0; j--) begin
      if ((j > int'(cur)) && !mask[j]) begin
        nxt = SW'(j);
      end
    end
  end

endmodule

// File: rtl/stage_sequencer.sv
// N-stage multicycle instruction sequencer with stage skipping, stall,
// halt/restart, continuous or single-shot operation and a retire counter.
module stage_sequencer
  import seq_pkg::*;
#(
  parameter int N_STAGES   = 5,
  parameter int CNT_W      = 16,
  parameter bit CONTINUOUS = 1'b1
) (
  input logic               m_clock,
  input logic               p_reset,
  stage_sequencer_if.slave  bus
);

  localparam int SW = sw_of(N_STAGES);
  // Fetch and writeback can never be skipped.
  localparam logic [N_STAGES-1:0] ENDS  = {1'b1, {(N_STAGES-1){1'b0}}} | N_STAGES'(1);
  localparam logic [N_STAGES-1:0] INNER = ~ENDS;

  mode_t               mode_q, mode_d;
  logic [SW-1:0]       idx_q, idx_d;
  logic [N_STAGES-1:0] mask_q, mask_d;
  logic                retire_q, retire_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic [SW-1:0]       next_idx;
  logic                active;
  logic                legal;
  logic                last;
  logic [N_STAGES-1:0] stage_oh_w;

  seq_next_stage #(
    .N_STAGES (N_STAGES),
    .SW       (SW)
  ) u_next (
    .mask (mask_q),
    .cur  (idx_q),
    .nxt  (next_idx)
  );

  assign active = (mode_q == ST_ACTIVE);
  assign legal  = (int'(idx_q) < N_STAGES);
  assign last   = (idx_q == SW'(N_STAGES - 1));

  // Next-state logic in priority order: halt, start, illegal recovery, stall, advance.
  always_comb begin
    mode_d   = mode_q;
    idx_d    = idx_q;
    mask_d   = mask_q;
    retire_d = 1'b0;
    cnt_d    = cnt_q;
    if (bus.halt) begin
      mode_d = ST_IDLE;
      idx_d  = SW'(IDLE_IDX);
    end else if (bus.start) begin
      mode_d = ST_ACTIVE;
      idx_d  = SW'(FETCH_IDX);
      mask_d = bus.skip_mask & INNER;
    end else if (active) begin
      if (!legal) begin
        mode_d = ST_IDLE;
        idx_d  = SW'(IDLE_IDX);
      end else if (bus.stall) begin
        mode_d = mode_q;
      end else if (last) begin
        retire_d = 1'b1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (CONTINUOUS) begin
          mode_d = ST_ACTIVE;
          idx_d  = SW'(FETCH_IDX);
          mask_d = bus.skip_mask & INNER;
        end else begin
          mode_d = ST_IDLE;
          idx_d  = SW'(IDLE_IDX);
        end
      end else begin
        idx_d = next_idx;
      end
    end
  end

  // State, latched mask, retire pulse and counter; async reset clears everything.
  always_ff @(posedge m_clock or posedge p_reset) begin
    if (p_reset) begin
      mode_q   <= ST_IDLE;
      idx_q    <= SW'(IDLE_IDX);
      mask_q   <= '0;
      retire_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      mode_q   <= mode_d;
      idx_q    <= idx_d;
      mask_q   <= mask_d;
      retire_q <= retire_d;
      cnt_q    <= cnt_d;
    end
  end

  // One-hot stage decode from the registered state; all zero when idle.
  always_comb begin
    stage_oh_w = '0;
    for (int i = 0; i < N_STAGES; i++) begin
      if (active && (idx_q == SW'(i))) begin
        stage_oh_w[i] = 1'b1;
      end
    end
  end

  assign bus.stage_oh     = stage_oh_w;
  assign bus.stage_idx    = active ? idx_q : SW'(IDLE_IDX);
  assign bus.busy         = active;
  assign bus.retire       = retire_q;
  assign bus.retire_count = cnt_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// Directed bench for stage_sequencer: a continuous 5-stage instance and a
// single-shot 5-stage instance with a 2-bit retire counter.
module tb_stage_sequencer;

  logic m_clock;
  logic p_reset;

  int n_vec;
  int n_miss;

  stage_sequencer_if #(.N_STAGES(5), .CNT_W(16)) ifc ();
  stage_sequencer_if #(.N_STAGES(5), .CNT_W(2))  ifs ();

  stage_sequencer #(.N_STAGES(5), .CNT_W(16), .CONTINUOUS(1'b1)) dut_c (
    .m_clock (m_clock),
    .p_reset (p_reset),
    .bus     (ifc)
  );

  stage_sequencer #(.N_STAGES(5), .CNT_W(2), .CONTINUOUS(1'b0)) dut_s (
    .m_clock (m_clock),
    .p_reset (p_reset),
    .bus     (ifs)
  );

  initial m_clock = 1'b0;
  always #5 m_clock = ~m_clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the active edge.
  task automatic tick();
    @(posedge m_clock);
    #1;
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;
    p_reset = 1'b1;
    ifc.start = 1'b0; ifc.stall = 1'b0; ifc.halt = 1'b0; ifc.skip_mask = '0;
    ifs.start = 1'b0; ifs.stall = 1'b0; ifs.halt = 1'b0; ifs.skip_mask = '0;
    #12;
    chk("rst_oh",    32'(ifc.stage_oh), 32'h0);
    chk("rst_idx",   32'(ifc.stage_idx), 32'h0);
    chk("rst_busy",  32'(ifc.busy), 32'h0);
    chk("rst_ret",   32'(ifc.retire), 32'h0);
    chk("rst_cnt",   32'(ifc.retire_count), 32'h0);
    p_reset = 1'b0;

    // Plain continuous run, no skips.
    ifc.start = 1'b1; ifc.skip_mask = 5'b00000;
    tick();
    ifc.start = 1'b0;
    for (int k = 0; k <= 10; k++) begin
      if (k > 0) tick();
      chk($sformatf("run_oh%0d", k), 32'(ifc.stage_oh), 32'(1) << (k % 5));
      chk($sformatf("run_ret%0d", k), 32'(ifc.retire), ((k % 5 == 0) && (k > 0)) ? 32'h1 : 32'h0);
    end
    chk("run_cnt", 32'(ifc.retire_count), 32'd2);
    ifc.halt = 1'b1;
    tick();
    ifc.halt = 1'b0;
    chk("halt_busy", 32'(ifc.busy), 32'h0);
    chk("halt_oh",   32'(ifc.stage_oh), 32'h0);
    chk("halt_ret",  32'(ifc.retire), 32'h0);
    tick();
    chk("idle_hold", 32'(ifc.busy), 32'h0);

    // All skip bits set: bits 0/4 ignored, 2-cycle instructions.
    ifc.start = 1'b1; ifc.skip_mask = 5'b11111;
    tick();
    ifc.start = 1'b0;
    chk("sk_oh0", 32'(ifc.stage_oh), 32'b00001);
    tick();
    chk("sk_oh1", 32'(ifc.stage_oh), 32'b10000);
    chk("sk_ret1", 32'(ifc.retire), 32'h0);
    tick();
    chk("sk_oh2", 32'(ifc.stage_oh), 32'b00001);
    chk("sk_ret2", 32'(ifc.retire), 32'h1);
    chk("sk_cnt", 32'(ifc.retire_count), 32'd3);
    tick();
    chk("sk_oh3", 32'(ifc.stage_oh), 32'b10000);
    ifc.halt = 1'b1;
    tick();
    ifc.halt = 1'b0;

    // Skip stage 2, stall at stage 1, change mask mid-instruction.
    ifc.start = 1'b1; ifc.skip_mask = 5'b00100;
    tick();
    ifc.start = 1'b0; ifc.skip_mask = 5'b01010;
    chk("st_idx0", 32'(ifc.stage_idx), 32'd0);
    tick();
    chk("st_idx1", 32'(ifc.stage_idx), 32'd1);
    ifc.stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("st_hold%0d", k), 32'(ifc.stage_idx), 32'd1);
      chk($sformatf("st_ret%0d", k), 32'(ifc.retire), 32'h0);
    end
    ifc.stall = 1'b0;
    tick();
    chk("st_idx3", 32'(ifc.stage_idx), 32'd3);
    tick();
    chk("st_idx4", 32'(ifc.stage_idx), 32'd4);
    tick();
    chk("st_wrap", 32'(ifc.stage_idx), 32'd0);
    chk("st_wret", 32'(ifc.retire), 32'h1);
    chk("st_cnt",  32'(ifc.retire_count), 32'd4);
    // Mask 01010 re-latched at the wrap: 0 -> 2 -> 4.
    tick();
    chk("rl_idx2", 32'(ifc.stage_idx), 32'd2);
    tick();
    chk("rl_idx4", 32'(ifc.stage_idx), 32'd4);
    ifc.halt = 1'b1;
    tick();
    ifc.halt = 1'b0;
    chk("rl_cnt", 32'(ifc.retire_count), 32'd4);

    // Restart from stage 3, then halt together with start.
    ifc.start = 1'b1; ifc.skip_mask = 5'b00000;
    tick();
    ifc.start = 1'b0;
    tick(); tick(); tick();
    chk("rs_idx3", 32'(ifc.stage_idx), 32'd3);
    ifc.start = 1'b1;
    tick();
    ifc.start = 1'b0;
    chk("rs_idx0", 32'(ifc.stage_idx), 32'd0);
    chk("rs_oh0",  32'(ifc.stage_oh), 32'b00001);
    chk("rs_ret",  32'(ifc.retire), 32'h0);
    chk("rs_cnt",  32'(ifc.retire_count), 32'd4);
    tick();
    chk("rs_idx1", 32'(ifc.stage_idx), 32'd1);
    ifc.start = 1'b1; ifc.halt = 1'b1;
    tick();
    ifc.start = 1'b0; ifc.halt = 1'b0;
    chk("hs_busy", 32'(ifc.busy), 32'h0);
    chk("hs_oh",   32'(ifc.stage_oh), 32'h0);
    chk("hs_ret",  32'(ifc.retire), 32'h0);

    // Single-shot instance, 2-bit counter wraps.
    for (int n = 1; n <= 5; n++) begin
      ifs.start = 1'b1; ifs.skip_mask = 5'b00000;
      tick();
      ifs.start = 1'b0;
      chk($sformatf("ss%0d_busy", n), 32'(ifs.busy), 32'h1);
      for (int s = 1; s < 5; s++) begin
        tick();
        chk($sformatf("ss%0d_idx%0d", n, s), 32'(ifs.stage_idx), 32'(s));
      end
      tick();
      chk($sformatf("ss%0d_done", n), 32'(ifs.busy), 32'h0);
      chk($sformatf("ss%0d_ret", n), 32'(ifs.retire), 32'h1);
      chk($sformatf("ss%0d_cnt", n), 32'(ifs.retire_count), 32'(n % 4));
      tick();
      chk($sformatf("ss%0d_idle", n), 32'(ifs.busy), 32'h0);
      chk($sformatf("ss%0d_ret0", n), 32'(ifs.retire), 32'h0);
    end

    // Asynchronous reset in the middle of stage 2.
    ifc.start = 1'b1;
    tick();
    ifc.start = 1'b0;
    tick(); tick();
    chk("ar_idx2", 32'(ifc.stage_idx), 32'd2);
    #2;
    p_reset = 1'b1;
    #1;
    chk("ar_oh",   32'(ifc.stage_oh), 32'h0);
    chk("ar_idx",  32'(ifc.stage_idx), 32'h0);
    chk("ar_busy", 32'(ifc.busy), 32'h0);
    chk("ar_ret",  32'(ifc.retire), 32'h0);
    chk("ar_cnt",  32'(ifc.retire_count), 32'h0);
    chk("ar_scnt", 32'(ifs.retire_count), 32'h0);
    #1;
    p_reset = 1'b0;
    tick(); tick();
    chk("ar_stay", 32'(ifc.busy), 32'h0);
    chk("ar_stret", 32'(ifc.retire), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
